// File: rtl/div_unit_rv32m_if.sv
// Handshake bundle between the EX stage and the RV32M divider.
// The divider side takes the slave modport.
interface div_unit_rv32m_if #(
  parameter int WIDTH = 32
);
  logic             div_en;
  logic             div_signed;
  logic             flush;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             div_stall;

  modport master (
    output div_en, div_signed, flush,
    output dividend, divisor,
    input  quotient, remainder,
    input  done, div_stall
  );

  modport slave (
    input  div_en, div_signed, flush,
    input  dividend, divisor,
    output quotient, remainder,
    output done, div_stall
  );
endinterface

// File: rtl/div_unit_rv32m.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; sign fix-up in a separate cycle.
module div_unit_rv32m #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  div_unit_rv32m_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   d_q;
  logic [WIDTH:0]   p_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic             accept;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH:0]   p_sh;
  logic             ge;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] a_nx;
  logic             last;
  logic             unused_p;

  assign accept = bus.div_en & ~bus.flush
                & (state_q == IDLE);

  assign sgn_a = bus.div_signed
               & bus.dividend[WIDTH-1];
  assign sgn_b = bus.div_signed
               & bus.divisor[WIDTH-1];
  assign mag_a = sgn_a ? -bus.dividend
                       : bus.dividend;
  assign mag_b = sgn_b ? -bus.divisor
                       : bus.divisor;

  assign div_zero = (bus.divisor == '0);
  assign ovf = bus.div_signed
             & (bus.dividend ==
                {1'b1, {(WIDTH-1){1'b0}}})
             & (bus.divisor == '1);
  assign special = div_zero | ovf;

  // P stays below D, so its top bit is free
  // to absorb the shift without overflow.
  assign p_sh = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign ge   = (p_sh >= d_q);
  assign p_nx = ge ? (p_sh - d_q) : p_sh;
  assign a_nx = {a_q[WIDTH-2:0], ge};
  assign last = (count_q == CW'(WIDTH-1));

  assign unused_p = p_q[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = special ? DONE : ITER;
      end
      ITER: begin
        if (bus.flush) state_d = IDLE;
        else if (last) state_d = FIX;
      end
      FIX:     state_d = bus.flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      a_q     <= '0;
      d_q     <= '0;
      p_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            count_q <= '0;
            a_q     <= mag_a;
            d_q     <= {1'b0, mag_b};
            p_q     <= '0;
            neg_q_q <= sgn_a ^ sgn_b;
            neg_r_q <= sgn_a;
            if (div_zero) begin
              quot_q <= '1;
              rem_q  <= bus.dividend;
            end else if (ovf) begin
              quot_q <= bus.dividend;
              rem_q  <= '0;
            end
          end
        end
        ITER: begin
          p_q     <= p_nx;
          a_q     <= a_nx;
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          if (!bus.flush) begin
            quot_q <= neg_q_q ? -a_q : a_q;
            rem_q  <= neg_r_q ? -p_q[WIDTH-1:0]
                              : p_q[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.done      = (state_q == DONE);
  assign bus.div_stall =
      (bus.div_en & ~bus.flush & (state_q == IDLE))
    | (state_q == ITER)
    | (state_q == FIX);
endmodule
